led_matrix_scanner: RTL and testbench

- Downstream consumer of the 16x16 bicolour frame (RedPixels/GrnPixels) produced by the pattern/game-of-life stages.
- Captures a coherent snapshot of the frame at each frame boundary.
- Time-multiplexes the frame onto the physical matrix one row at a time, with a blanking gap between rows to suppress ghosting.
- Outputs drive the board row-select and column pins directly.

---
 rtl/led_matrix_scanner_if.sv | 13 +
 rtl/led_matrix_scanner.sv | 95 +++++++++
 tb/tb_led_matrix_scanner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: frame inputs (EN, RedPixels, GrnPixels) and matrix outputs (ROW_SEL, RED_COL, GRN_COL, ROW_IDX, FRAME_START)
interface led_matrix_scanner_if;
  logic EN;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [15:0] ROW_SEL;
  logic [15:0] RED_COL;
  logic [15:0] GRN_COL;
  logic [3:0] ROW_IDX;
  logic FRAME_START;
  modport master(output EN, RedPixels, GrnPixels, input ROW_SEL, RED_COL, GRN_COL, ROW_IDX, FRAME_START);
  modport slave(input EN, RedPixels, GrnPixels, output ROW_SEL, RED_COL, GRN_COL, ROW_IDX, FRAME_START);
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: snapshots a 16x16 bicolour frame at LOAD and scans it row by row (CLK, RST, bus: EN/pixels in, row/column drive out)
module led_matrix_scanner #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input logic CLK,
  input logic RST,
  led_matrix_scanner_if.slave bus
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DW_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LD = CW'(BLANK > 0 ? BLANK - 1 : 0);
  localparam bit NOBLANK = BLANK == 0;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_DRIVE} state_t;
  state_t state_q, state_d, next_st;
  logic [CW-1:0] cnt_q, cnt_d, next_cnt;
  logic [3:0] row_q, row_d;
  logic [15:0][15:0] sh_red_q, sh_grn_q, src_red, src_grn;
  logic [15:0] row_sel_q, row_sel_d, red_q, red_d, grn_q, grn_d;
  logic fs_q, fs_d, drv;
  assign next_st = NOBLANK ? S_DRIVE : S_BLANK;
  assign next_cnt = NOBLANK ? DW_LD : BL_LD;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        state_d = next_st;
        cnt_d = next_cnt;
        row_d = '0;
      end
      S_BLANK:
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d = DW_LD;
        end else cnt_d = cnt_q - 1'b1;
      S_DRIVE:
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (row_q == 4'd15) begin
          state_d = S_LOAD;
          row_d = '0;
        end else begin
          state_d = next_st;
          cnt_d = next_cnt;
          row_d = row_q + 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    if (!bus.EN) begin
      state_d = S_IDLE;
      row_d = '0;
    end
    // a row entered straight from LOAD must see the frame being latched on this edge
    src_red = state_q == S_LOAD ? bus.RedPixels : sh_red_q;
    src_grn = state_q == S_LOAD ? bus.GrnPixels : sh_grn_q;
    drv = state_d == S_DRIVE;
    row_sel_d = drv ? 16'd1 << row_d : '0;
    red_d = drv ? src_red[row_d] : '0;
    grn_d = drv ? src_grn[row_d] : '0;
    fs_d = state_d == S_LOAD;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      row_q <= '0;
      sh_red_q <= '0;
      sh_grn_q <= '0;
      row_sel_q <= '0;
      red_q <= '0;
      grn_q <= '0;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      row_sel_q <= row_sel_d;
      red_q <= red_d;
      grn_q <= grn_d;
      fs_q <= fs_d;
      if (state_q == S_LOAD) begin
        sh_red_q <= bus.RedPixels;
        sh_grn_q <= bus.GrnPixels;
      end
    end
  end
  assign bus.ROW_SEL = row_sel_q;
  assign bus.RED_COL = red_q;
  assign bus.GRN_COL = grn_q;
  assign bus.ROW_IDX = row_q;
  assign bus.FRAME_START = fs_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench for two scanner configurations (DWELL=4/BLANK=2 and DWELL=1/BLANK=0)
module tb_led_matrix_scanner;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN = 1'b0;
  logic [15:0][15:0] red = '0;
  logic [15:0][15:0] grn = '0;
  always #5 CLK = ~CLK;
  led_matrix_scanner_if ifa();
  led_matrix_scanner_if ifb();
  assign ifa.EN = EN;
  assign ifa.RedPixels = red;
  assign ifa.GrnPixels = grn;
  assign ifb.EN = EN;
  assign ifb.RedPixels = red;
  assign ifb.GrnPixels = grn;
  led_matrix_scanner #(.DWELL(4), .BLANK(2)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
  led_matrix_scanner #(.DWELL(1), .BLANK(0)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));
  typedef struct packed {
    logic [15:0] row_sel;
    logic [15:0] red;
    logic [15:0] grn;
    logic [3:0] idx;
    logic fs;
  } out_t;
  out_t qa[$];
  out_t qb[$];
  int errors = 0;
  int checks = 0;
  int dw[2] = '{4, 1};
  int bl[2] = '{2, 0};
  bit run[2];
  int pos[2];
  logic [15:0][15:0] sr[2];
  logic [15:0][15:0] sg[2];
  // frame position 0 is the LOAD cycle; then 16 slots of bl blank cycles followed by dw lit cycles
  function automatic out_t model_out(int d);
    out_t o;
    int k, r;
    o = '0;
    if (!run[d]) return o;
    if (pos[d] == 0) begin
      o.fs = 1'b1;
      return o;
    end
    k = pos[d] - 1;
    r = k / (bl[d] + dw[d]);
    o.idx = 4'(r);
    if (k % (bl[d] + dw[d]) >= bl[d]) begin
      o.row_sel = 16'd1 << r;
      o.red = sr[d][r];
      o.grn = sg[d][r];
    end
    return o;
  endfunction
  task automatic tick();
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (RST || !EN) run[d] = 1'b0;
      else if (!run[d]) begin
        run[d] = 1'b1;
        pos[d] = 0;
      end else begin
        if (pos[d] == 0) begin
          sr[d] = red;
          sg[d] = grn;
        end
        pos[d] = (pos[d] + 1) % (16 * (bl[d] + dw[d]) + 1);
      end
    end
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    #1;
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_row(int row, bit lit);
    int n;
    n = 0;
    while (!(run[0] && pos[0] > 0 && (pos[0] - 1) / 6 == row && (((pos[0] - 1) % 6) >= 2) == lit) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_row%0d got=timeout exp=reached", row);
    end
  endtask
  task automatic chk(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got sel=%h r=%h g=%h idx=%0d fs=%b exp sel=%h r=%h g=%h idx=%0d fs=%b", name,
               act.row_sel, act.red, act.grn, act.idx, act.fs, exp.row_sel, exp.red, exp.grn, exp.idx, exp.fs);
    end
  endtask
  always @(negedge CLK) begin
    if (qa.size() > 0) chk("dut_a", {ifa.ROW_SEL, ifa.RED_COL, ifa.GRN_COL, ifa.ROW_IDX, ifa.FRAME_START}, qa.pop_front());
    if (qb.size() > 0) chk("dut_b", {ifb.ROW_SEL, ifb.RED_COL, ifb.GRN_COL, ifb.ROW_IDX, ifb.FRAME_START}, qb.pop_front());
  end
  initial begin
    ticks(2);
    RST = 1'b0;
    ticks(10);
    for (int r = 0; r < 16; r++) red[r] = 16'd1 << r;
    EN = 1'b1;
    ticks(200);
    wait_row(2, 1'b1);
    grn[5] = 16'hFFFF;
    ticks(200);
    wait_row(7, 1'b1);
    EN = 1'b0;
    ticks(5);
    EN = 1'b1;
    ticks(120);
    wait_row(10, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ticks(120);
    red = '1;
    grn = '1;
    ticks(60);
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 16; r++) begin
        red[r] = 16'($urandom);
        grn[r] = 16'($urandom);
      end
      EN = $urandom_range(0, 63) != 0;
      RST = $urandom_range(0, 199) == 0;
      tick();
    end
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
